// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: round-robin, burst-limited arbiter between the CPU (m0) and the display loader (m1)
// for the shared VRAM port. Define VRAM_ARB_VBLANK_PRIO_EN to give m1 strict priority while vblank=1.
module vram_bus_arbiter #(
  parameter int MAX_BURST  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_din,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_din,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW:0] MAX_BEATS = (BW + 1)'(MAX_BURST);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e                owner_q, owner_d, owner_rr_s;
  logic                  last_q, last_d;  // 1 = m1 was the most recent owner
  logic [BW-1:0]         beats_q, beats_d, beats_eff_s;
  logic [BW:0]           beats_inc_s;
  logic                  burst_done_s, acc0_s, acc1_s, rd_push_s, rv_s;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_m_q, tag_m_d;
  logic [31:0]           hold0_q, hold1_q;

  assign m0_gnt = (owner_q == OWN0);
  assign m1_gnt = (owner_q == OWN1);
  assign acc0_s = m0_req & m0_gnt;
  assign acc1_s = m1_req & m1_gnt;
  assign mem_en = acc0_s | acc1_s;

`ifdef VRAM_ARB_VBLANK_PRIO_EN
  logic vblank_q, vb_fall_s;
  assign vb_fall_s   = vblank_q & ~vblank;
  // Round-robin restarts from a fresh burst count when vblank ends.
  assign beats_eff_s = vb_fall_s ? {BW{1'b0}} : beats_q;
  assign owner_d     = (vblank && m1_req) ? OWN1 : owner_rr_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
    end
  end
`else
  logic unused_vblank_s;
  assign unused_vblank_s = vblank;
  assign beats_eff_s     = beats_q;
  assign owner_d         = owner_rr_s;
`endif

  // The current beat counts toward the burst, so the switch lands right after the last allowed beat.
  assign beats_inc_s  = {1'b0, beats_eff_s} + {{BW{1'b0}}, 1'b1};
  assign burst_done_s = (beats_inc_s >= MAX_BEATS);

  always_comb begin
    owner_rr_s = owner_q;
    case (owner_q)
      NONE: begin
        if (m0_req && m1_req) owner_rr_s = last_q ? OWN0 : OWN1;
        else if (m0_req)      owner_rr_s = OWN0;
        else if (m1_req)      owner_rr_s = OWN1;
        else                  owner_rr_s = NONE;
      end
      OWN0: begin
        if (m0_req && !(m1_req && burst_done_s)) owner_rr_s = OWN0;
        else if (m1_req)                         owner_rr_s = OWN1;
        else                                     owner_rr_s = NONE;
      end
      OWN1: begin
        if (m1_req && !(m0_req && burst_done_s)) owner_rr_s = OWN1;
        else if (m0_req)                         owner_rr_s = OWN0;
        else                                     owner_rr_s = NONE;
      end
      default: owner_rr_s = NONE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    beats_d = beats_eff_s;
    if (owner_d != owner_q) begin
      beats_d = {BW{1'b0}};
      if (owner_d == OWN0)      last_d = 1'b0;
      else if (owner_d == OWN1) last_d = 1'b1;
      else                      last_d = last_q;
    end else if (mem_en && (beats_inc_s <= MAX_BEATS)) begin
      beats_d = beats_inc_s[BW-1:0];
    end else begin
      beats_d = beats_eff_s;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    if (acc0_s) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_din  = m0_din;
    end else if (acc1_s) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_din  = m1_din;
    end else begin
      mem_we   = 1'b0;
    end
  end

  // Read tags travel alongside the memory pipeline so returns follow issue order, not the grant.
  assign rd_push_s = mem_en & ~mem_we;

  always_comb begin
    tag_v_d    = tag_v_q;
    tag_m_d    = tag_m_q;
    tag_v_d[0] = rd_push_s;
    tag_m_d[0] = acc1_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_m_d[i] = tag_m_q[i-1];
    end
  end

  assign rv_s      = tag_v_q[RD_LATENCY-1] & ~rst;
  assign m0_rvalid = rv_s & ~tag_m_q[RD_LATENCY-1];
  assign m1_rvalid = rv_s &  tag_m_q[RD_LATENCY-1];
  assign m0_rdata  = m0_rvalid ? mem_dout : hold0_q;
  assign m1_rdata  = m1_rvalid ? mem_dout : hold1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= NONE;
      last_q  <= 1'b1;
      beats_q <= {BW{1'b0}};
      tag_v_q <= {RD_LATENCY{1'b0}};
      tag_m_q <= {RD_LATENCY{1'b0}};
      hold0_q <= 32'd0;
      hold1_q <= 32'd0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      tag_v_q <= tag_v_d;
      tag_m_q <= tag_m_d;
      if (m0_rvalid) hold0_q <= mem_dout;
      if (m1_rvalid) hold1_q <= mem_dout;
    end
  end
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter: queued master commands, a latency-accurate memory model,
// beat/return scoreboards and per-scenario grant run checks.
`timescale 1ns/1ps
module tb_vram_bus_arbiter;
  localparam int MAXB = 8;
  localparam int RDL  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_din = 32'd0, m1_addr = 32'd0, m1_din = 32'd0;
  logic [31:0] mem_dout = 32'd0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_din;

  vram_bus_arbiter #(.MAX_BURST(MAXB), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] din; } cmd_t;
  typedef struct { int m; int n; int gap; } run_t;

  cmd_t        q0[$], q1[$], eb0[$], eb1[$];
  logic [31:0] er0[$], er1[$];
  int          ic0[$], ic1[$], bt_cyc[$], bt_m[$];
  run_t        exp_runs[$];
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  logic        acc0_seen = 1'b0, acc1_seen = 1'b0;
  logic [31:0] last0 = 32'd0, last1 = 32'd0, addr_seen = 32'd0;
  logic [31:0] dl [RDL];

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.din = d;
    if (m == 0) begin
      q0.push_back(c); eb0.push_back(c);
      if (!we) er0.push_back(rd_model(a));
    end else begin
      q1.push_back(c); eb1.push_back(c);
      if (!we) er1.push_back(rd_model(a));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m0_gnt || m1_gnt) && k < lim) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, (k >= lim)}, 32'd0);
    repeat (4) tick();
  endtask

  task automatic add_run(input int m, input int n, input int gap);
    run_t r;
    r.m = m; r.n = n; r.gap = gap;
    exp_runs.push_back(r);
  endtask

  // Walks the logged beats against the expected owner runs, starting at cycle c0.
  task automatic check_runs(input string tag, input int s, input int c0);
    int k, c;
    k = s; c = c0;
    foreach (exp_runs[r]) begin
      c += exp_runs[r].gap;
      for (int j = 0; j < exp_runs[r].n; j++) begin
        if (k < bt_m.size()) begin
          check({tag, "_owner"}, bt_m[k], exp_runs[r].m);
          check({tag, "_cycle"}, bt_cyc[k], c);
        end else begin
          check({tag, "_missing_beat"}, 32'd1, 32'd0);
        end
        k++; c++;
      end
    end
    check({tag, "_beat_count"}, bt_m.size() - s, k - s);
    exp_runs.delete();
  endtask

  // Master drivers and memory model, updated just after each rising edge.
  initial begin
    foreach (dl[i]) dl[i] = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = RDL - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = rd_model(addr_seen);
      mem_dout = dl[RDL-1];
      if (acc0_seen && q0.size() > 0) q0.delete(0);
      if (acc1_seen && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_din = q0[0].din;
      end else begin
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_din = 32'd0;
      end
      if (q1.size() > 0) begin
        m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_din = q1[0].din;
      end else begin
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_din = 32'd0;
      end
    end
  end

  // Monitor: beat scoreboard, read-return scoreboard and idle-port checks on the falling edge.
  initial begin
    cmd_t        e;
    logic        got;
    int          bm;
    logic [31:0] ev;
    forever begin
      @(negedge clk);
      acc0_seen = m0_req & m0_gnt;
      acc1_seen = m1_req & m1_gnt;
      addr_seen = mem_addr;
      if (rst !== 1'b1) begin
        check("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
        if (mem_en === 1'b1) begin
          got = 1'b0;
          if (m1_gnt === 1'b1) begin
            bm = 2;
            if (eb1.size() > 0) begin e = eb1.pop_front(); got = 1'b1; end
          end else begin
            bm = 1;
            if (eb0.size() > 0) begin e = eb0.pop_front(); got = 1'b1; end
          end
          bt_cyc.push_back(cyc);
          bt_m.push_back(bm);
          check("beat_expected", {31'd0, got}, 32'd1);
          if (got) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            check("mem_addr", mem_addr, e.addr);
            check("mem_din", mem_din, e.din);
            if (!e.we) begin
              if (bm == 1) ic0.push_back(cyc);
              else         ic1.push_back(cyc);
            end
          end
        end else begin
          check("idle_mem_we", {31'd0, mem_we}, 32'd0);
          check("idle_mem_addr", mem_addr, 32'd0);
          check("idle_mem_din", mem_din, 32'd0);
        end
        if (m0_rvalid === 1'b1) begin
          if (er0.size() > 0 && ic0.size() > 0) begin
            ev = er0.pop_front();
            check("m0_rdata", m0_rdata, ev);
            check("m0_rd_latency", cyc - ic0.pop_front(), RDL);
            last0 = ev;
          end else begin
            check("m0_rvalid_spurious", 32'd1, 32'd0);
          end
        end else begin
          check("m0_rdata_hold", m0_rdata, last0);
        end
        if (m1_rvalid === 1'b1) begin
          if (er1.size() > 0 && ic1.size() > 0) begin
            ev = er1.pop_front();
            check("m1_rdata", m1_rdata, ev);
            check("m1_rd_latency", cyc - ic1.pop_front(), RDL);
            last1 = ev;
          end else begin
            check("m1_rvalid_spurious", 32'd1, 32'd0);
          end
        end else begin
          check("m1_rdata_hold", m1_rdata, last1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int s, c;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // m0 alone writes four palette words
    s = bt_m.size(); c = cyc;
    for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, 32'h0630_0000 + 32'(i), 32'h1111_0000 + 32'(i));
    tick();
    check("t1_gnt_before_latency", {31'd0, m0_gnt}, 32'd0);
    tick();
    check("t1_gnt_after_latency", {31'd0, m0_gnt}, 32'd1);
    check("t1_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    wait_idle(50);
    add_run(1, 4, 0);
    check_runs("t1", s, c + 2);

    // m0 read followed by an m1 write; the read returns after the grant has moved
    s = bt_m.size(); c = cyc;
    push_cmd(0, 1'b0, 32'h0610_0005, 32'd0);
    tick();
    push_cmd(1, 1'b1, 32'h0620_0010, 32'hCAFE_0001);
    tick();
    check("t3_m0_issue", {31'd0, m0_gnt & mem_en}, 32'd1);
    tick();
    check("t3_m0_rvalid_early", {31'd0, m0_rvalid}, 32'd0);
    check("t3_m1_gnt_early", {31'd0, m1_gnt}, 32'd0);
    tick();
    check("t3_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    check("t3_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    check("t3_m0_rdata", m0_rdata, 32'h0610_0005 ^ 32'hA5A5_5A5A);
    check("t3_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    wait_idle(50);
    add_run(1, 1, 0);
    add_run(2, 1, 1);
    check_runs("t3", s, c + 2);

    // reset one cycle after m1 issues a read; in-flight returns must vanish
    c = cyc;
    for (int i = 0; i < 3; i++) push_cmd(1, 1'b0, 32'h0620_0100 + 32'(i), 32'd0);
    repeat (2) tick();
    check("t4_m1_issue", {31'd0, m1_gnt & mem_en}, 32'd1);
    tick();
    rst = 1'b1;
    q1.delete(); eb1.delete(); er1.delete(); ic1.delete();
    last0 = 32'd0; last1 = 32'd0;
    tick();
    check("t4_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    check("t4_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    check("t4_mem_en", {31'd0, mem_en}, 32'd0);
    check("t4_mem_addr", mem_addr, 32'd0);
    check("t4_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check("t4_m0_rdata", m0_rdata, 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // both masters continuously from NONE: M0 wins the tie, 8-beat bursts alternate
    s = bt_m.size(); c = cyc;
    for (int i = 0; i < 24; i++) begin
      push_cmd(0, 1'b1, 32'h0600_0000 + 32'(i), 32'h2000_0000 + 32'(i));
      push_cmd(1, 1'b1, 32'h0620_0000 + 32'(i), 32'h3000_0000 + 32'(i));
    end
    repeat (2) tick();
    check("t2_tie_m0", {31'd0, m0_gnt}, 32'd1);
    wait_idle(200);
    for (int r = 0; r < 6; r++) add_run((r % 2) + 1, MAXB, 0);
    check_runs("t2", s, c + 2);

    // m0 burst at beat 3 when vblank rises together with an m1 request
    s = bt_m.size(); c = cyc;
    for (int i = 0; i < 30; i++) push_cmd(0, 1'b1, 32'h0600_1000 + 32'(i), 32'h4000_0000 + 32'(i));
    repeat (4) tick();
    vblank = 1'b1;
    for (int i = 0; i < 20; i++) push_cmd(1, 1'b1, 32'h0620_1000 + 32'(i), 32'h5000_0000 + 32'(i));
    wait_idle(300);
    vblank = 1'b0;
`ifdef VRAM_ARB_VBLANK_PRIO_EN
    add_run(1, 4, 0);
    add_run(2, 20, 0);
    add_run(1, 26, 1);
`else
    add_run(1, 8, 0);
    add_run(2, 8, 0);
    add_run(1, 8, 0);
    add_run(2, 8, 0);
    add_run(1, 8, 0);
    add_run(2, 4, 0);
    add_run(1, 6, 1);
`endif
    check_runs("t5", s, c + 2);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
